// File: rtl/seg_pkg.sv
// seg_pkg: shared FSM states and active-low seven-segment patterns for seg_bcd_display.
//   Contents: state_e (IDLE/SHIFT/ENCODE), SEG_BLANK, SEG_MINUS, SEG_E, SEG_DIGITS[0..9].
//   Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_e;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
endpackage

// File: rtl/seg_digit_enc.sv
// seg_digit_enc: combinational BCD nibble to active-low seven-segment pattern.
//   nib_i  [3:0] BCD digit; 10..15 cannot occur after double-dabble and show blank
//   seg_o  [6:0] active-low {g,f,e,d,c,b,a}
module seg_digit_enc (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    import seg_pkg::*;
    always_comb seg_o = (nib_i <= 4'd9) ? SEG_DIGITS[nib_i] : SEG_BLANK;
endmodule

// File: rtl/seg_bcd_display.sv
// seg_bcd_display: sequential signed-binary to DIGITS-digit seven-segment driver (double-dabble).
//   clk, rst_n        clock, synchronous active-low reset
//   start, value      request conversion of the two's-complement value (accepted only when idle)
//   busy, done        conversion in progress / one-cycle pulse when outputs update
//   seg               DIGITS x 7 active-low patterns, digit 0 (ones) in [6:0]
//   sign_seg          minus sign for non-zero negative results, blank otherwise
//   overflow          magnitude does not fit in DIGITS decimal digits; all digits show "E"
//   Build option LEADING_ZERO_BLANK_EN: blank leading zero digits above digit 0.
module seg_bcd_display
    import seg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*7-1:0]   seg,
    output logic [6:0]            sign_seg,
    output logic                  overflow
);
    // One guard nibble above the displayed digits flags overflow during the shift.
    localparam int BW = 4 * DIGITS + 4;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic                neg_q, big_q, busy_q, done_q, ovf_q;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic                big_d;
    logic [BW-1:0]       bcd_q, bcd_adj;
    logic [DIGITS*7-1:0] seg_q, seg_d, dig_seg;
    logic [6:0]          sign_q, sign_d;
    logic                ovf_d, lead;

    // Magnitude of the incoming operand; the most negative value maps to 2^(WIDTH-1).
    // The range test is done on the full magnitude because the BCD register may
    // lose digits beyond the guard nibble for wide inputs.
    always_comb begin
        mag_d = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
        big_d = 32'(mag_d) >= LIMIT;
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BW / 4; i++)
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg_digit_enc u_enc (
            .nib_i (bcd_q[4*g +: 4]),
            .seg_o (dig_seg[7*g +: 7])
        );
    end

    // Digits are walked from the most significant down so that lead stays set
    // only while every digit above (and including) the current one is zero.
    always_comb begin
        ovf_d  = big_q || (bcd_q[BW-1 -: 4] != 4'd0);
        sign_d = (neg_q && (big_q || bcd_q != '0)) ? SEG_MINUS : SEG_BLANK;
        lead   = 1'b1;
        seg_d  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead = lead && (bcd_q[4*i +: 4] == 4'd0);
            seg_d[7*i +: 7] = ovf_d ? SEG_E : (LZB && lead && i > 0) ? SEG_BLANK : dig_seg[7*i +: 7];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            big_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= {DIGITS{SEG_DIGITS[0]}};
            sign_q  <= SEG_BLANK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    neg_q   <= value[WIDTH-1];
                    mag_q   <= mag_d;
                    big_q   <= big_d;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj[BW-2:0], mag_q, 1'b0};
                    cnt_q          <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= ENCODE;
                end
                ENCODE: begin
                    seg_q   <= seg_d;
                    sign_q  <= sign_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign seg      = seg_q;
    assign sign_seg = sign_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_seg_bcd_display.sv
// tb_seg_bcd_display: checks seg_bcd_display (DIGITS=3 and DIGITS=2) against a decimal-arithmetic model.
module tb_seg_bcd_display;
    localparam int W = 8;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [W-1:0] value = '0;
    logic busy3, done3, ovf3, busy2, done2, ovf2;
    logic [20:0] seg3;
    logic [13:0] seg2;
    logic [6:0] sgn3, sgn2;
    int total = 0, passed = 0, done_cnt = 0;
    int rem [2];
    logic e_done [2];
    logic [35:0] e_out [2], pend [2];

    always #5 clk = ~clk;

    seg_bcd_display #(.WIDTH(W), .DIGITS(3)) d3 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy3), .done(done3), .seg(seg3), .sign_seg(sgn3), .overflow(ovf3)
    );
    seg_bcd_display #(.WIDTH(W), .DIGITS(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy2), .done(done2), .seg(seg2), .sign_seg(sgn2), .overflow(ovf2)
    );

    // Expected display from plain decimal arithmetic: {overflow, sign, 28-bit digit field}.
    function automatic logic [35:0] model(input int v, input int d);
        int mag, p;
        logic [27:0] s;
        logic ovf, neg;
        neg = v < 0;
        mag = neg ? -v : v;
        ovf = mag >= 10 ** d;
        s   = '0;
        p   = 1;
        for (int i = 0; i < d; i++) begin
            s[7*i +: 7] = ovf ? 7'b0000110 : (LZB && i > 0 && mag < p) ? 7'b1111111 : PAT[(mag / p) % 10];
            p = p * 10;
        end
        return {ovf, (neg && mag != 0) ? 7'b0111111 : 7'b1111111, s};
    endfunction

    function automatic logic [35:0] rst_out(input int d);
        logic [27:0] s;
        s = '0;
        for (int i = 0; i < d; i++) s[7*i +: 7] = 7'b1000000;
        return {1'b0, 7'b1111111, s};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Transaction-level timing: an accepted start keeps the block busy for W+1 edges,
    // after which the new result appears together with a one-cycle done.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_done[k] = 1'b0;
            if (!rst_n) begin
                rem[k]   = 0;
                e_out[k] = rst_out(k == 0 ? 3 : 2);
            end else if (rem[k] == 0) begin
                if (start) begin
                    rem[k]  = W + 1;
                    pend[k] = model(int'($signed(value)), k == 0 ? 3 : 2);
                end
            end else begin
                rem[k] = rem[k] - 1;
                if (rem[k] == 0) begin
                    e_out[k]  = pend[k];
                    e_done[k] = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (done3) done_cnt++;
        check("d3_busy", 36'(busy3), 36'(rem[0] != 0));
        check("d3_done", 36'(done3), 36'(e_done[0]));
        check("d3_out", {ovf3, sgn3, 7'b0, seg3}, e_out[0]);
        check("d2_busy", 36'(busy2), 36'(rem[1] != 0));
        check("d2_done", 36'(done2), 36'(e_done[1]));
        check("d2_out", {ovf2, sgn2, 14'b0, seg2}, e_out[1]);
    end

    task automatic convert(input logic [W-1:0] v, output int n);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done3 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, c;
        logic [W-1:0] vals [6] = '{8'd99, 8'd100, 8'hFB, 8'd10, 8'd1, 8'h9C};
        repeat (2) @(negedge clk);
        check("rst_seg3", 36'(seg3), 36'(21'b1000000_1000000_1000000));
        check("rst_sign3", 36'(sgn3), 36'(7'b1111111));
        check("rst_flags", {33'b0, busy3, done3, ovf3}, 36'd0);
        rst_n = 1'b1;

        convert(8'd0, n);
        check("lat_zero", 36'(n), 36'd10);
        check("zero_seg3", 36'(seg3), LZB ? 36'(21'b1111111_1111111_1000000) : 36'(21'b1000000_1000000_1000000));
        check("zero_sign3", {28'b0, ovf3, sgn3}, 36'(8'b0_1111111));

        convert(8'd127, n);
        check("lat_127", 36'(n), 36'd10);
        check("p127_seg3", 36'(seg3), 36'(21'b1111001_0100100_1111000));
        check("p127_sign3", 36'(sgn3), 36'(7'b1111111));
        check("p127_d2", {21'b0, ovf2, seg2}, 36'(15'b1_0000110_0000110));

        convert(8'h80, n);
        check("m128_seg3", 36'(seg3), 36'(21'b1111001_0100100_0000000));
        check("m128_sign3", 36'(sgn3), 36'(7'b0111111));

        convert(8'hFF, n);
        check("m1_seg3", 36'(seg3), LZB ? 36'(21'b1111111_1111111_1111001) : 36'(21'b1000000_1000000_1111001));
        check("m1_sign3", 36'(sgn3), 36'(7'b0111111));

        foreach (vals[i]) begin
            convert(vals[i], n);
            check("lat_vec", 36'(n), 36'd10);
        end

        // Back-to-back: start held through the done cycle starts the next conversion.
        @(negedge clk);
        value = 8'd10;
        start = 1'b1;
        @(negedge clk);
        value = 8'hDB;
        n = 1;
        while (!done3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first", 36'(n), 36'd10);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap", 36'(n), 36'd10);
        check("m37_sign3", 36'(sgn3), 36'(7'b0111111));

        // Abort: second start ignored, reset mid-conversion, no done afterwards.
        @(negedge clk);
        value = 8'd42;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        value = 8'd5;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_pre", 36'(busy3), 36'd1);
        @(negedge clk);
        rst_n = 1'b0;
        c = done_cnt;
        @(negedge clk);
        check("abort_busy", {34'b0, busy3, busy2}, 36'd0);
        check("abort_seg3", 36'(seg3), 36'(21'b1000000_1000000_1000000));
        check("abort_sign3", 36'(sgn3), 36'(7'b1111111));
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_no_done", 36'(done_cnt), 36'(c));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
